// File: rtl/retire_rat_pkg.sv
// retire_rat_pkg
// Shared constants for the retirement RAT: retire width, physical register
// file geometry, architectural register count and the register-type encoding
// carried on the rdType buses.
package retire_rat_pkg;

  localparam int DEF_RETIRE_RATE   = 2;
  localparam int DEF_INT_PRF_DEPTH = 64;
  localparam int DEF_INT_PRF_LEN   = 6;
  localparam int DEF_FP_PRF_DEPTH  = 64;
  localparam int DEF_FP_PRF_LEN    = 6;
  localparam int DEF_PRF_MAX_LEN   = 6;

  localparam int ARCH_REGS = 32;
  localparam int ARCH_LEN  = 5;

  localparam logic REG_TYPE_INT = 1'b0;
  localparam logic REG_TYPE_FP  = 1'b1;

endpackage

// File: rtl/retire_rat_table.sv
// retire_rat_table
// One committed architectural-to-physical map (32 entries) plus the vector of
// physical registers currently referenced by it. Performs the oldest-first
// bypass lookup for each retire slot so that a slot sees the mapping left by
// any older slot of the same group.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   act           per-slot write request already filtered for this register type
//   rd            per-slot architectural destination, ARCH_LEN bits each
//   prd           per-slot new physical destination, LEN bits each
//   free_en       per-slot: this slot really updates the table (r0 filtered)
//   old_prd       per-slot previous mapping, LEN bits each (combinational)
//   map_bits      registered mapped-register vector
module retire_rat_table
  import retire_rat_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int LEN         = 6,
  parameter bit SUPPRESS_R0 = 1'b0,
  parameter int RATE        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RATE-1:0]          act,
  input  logic [RATE*ARCH_LEN-1:0] rd,
  input  logic [RATE*LEN-1:0]      prd,
  output logic [RATE-1:0]          free_en,
  output logic [RATE*LEN-1:0]      old_prd,
  output logic [DEPTH-1:0]         map_bits
);

  // Reset image: every architectural register maps to the same-numbered
  // physical register; r0 is excluded from the vector when it is hardwired.
  function automatic logic [DEPTH-1:0] map_reset_f();
    logic [DEPTH-1:0] bits;
    bits = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      bits[i] = 1'b1;
    end
    if (SUPPRESS_R0) begin
      bits[0] = 1'b0;
    end else begin
      bits[0] = 1'b1;
    end
    return bits;
  endfunction

  localparam logic [DEPTH-1:0] MAP_RST = map_reset_f();

  logic [LEN-1:0]      table_r [ARCH_REGS];
  logic [DEPTH-1:0]    map_r;
  logic [ARCH_LEN-1:0] rd_s    [RATE];
  logic [LEN-1:0]      prd_s   [RATE];
  logic [LEN-1:0]      old_s   [RATE];
  logic [RATE-1:0]     eff_s;
  logic [RATE-1:0]     final_s;
  logic [DEPTH-1:0]    map_nxt_s;

  // Unpack slot buses and drop writes to a hardwired r0.
  always_comb begin
    for (int k = 0; k < RATE; k++) begin
      rd_s[k]  = rd[k*ARCH_LEN +: ARCH_LEN];
      prd_s[k] = prd[k*LEN +: LEN];
      if (SUPPRESS_R0 && (rd_s[k] == 5'd0)) begin
        eff_s[k] = 1'b0;
      end else begin
        eff_s[k] = act[k];
      end
    end
  end

  // Bypass lookup (youngest older slot wins) and "last writer" detection,
  // which decides whose prd actually ends up installed in the table.
  always_comb begin
    old_prd = '0;
    for (int k = 0; k < RATE; k++) begin
      old_s[k]   = table_r[rd_s[k]];
      final_s[k] = eff_s[k];
      for (int j = 0; j < RATE; j++) begin
        if ((j < k) && eff_s[j] && (rd_s[j] == rd_s[k])) begin
          old_s[k] = prd_s[j];
        end else if ((j > k) && eff_s[j] && (rd_s[j] == rd_s[k])) begin
          final_s[k] = 1'b0;
        end else begin
          final_s[k] = final_s[k];
        end
      end
      old_prd[k*LEN +: LEN] = old_s[k];
    end
    free_en = eff_s;
  end

  // Next map vector: all clears first, then sets, so a set wins on the same index.
  always_comb begin
    map_nxt_s = map_r;
    for (int k = 0; k < RATE; k++) begin
      if (eff_s[k]) begin
        map_nxt_s[old_s[k]] = 1'b0;
      end else begin
        map_nxt_s = map_nxt_s;
      end
    end
    for (int k = 0; k < RATE; k++) begin
      if (final_s[k]) begin
        map_nxt_s[prd_s[k]] = 1'b1;
      end else begin
        map_nxt_s = map_nxt_s;
      end
    end
  end

  // Table and map vector state; later slots overwrite earlier ones on duplicate rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        table_r[i] <= LEN'(i);
      end
      map_r <= MAP_RST;
    end else begin
      for (int k = 0; k < RATE; k++) begin
        if (eff_s[k]) begin
          table_r[rd_s[k]] <= prd_s[k];
        end
      end
      map_r <= map_nxt_s;
    end
  end

  assign map_bits = map_r;

endmodule

// File: rtl/retire_rat.sv
// retire_rat
// Retirement register alias table. For every retiring instruction that writes
// rd it returns the previous physical mapping to the free list (one cycle
// later, registered), installs the new mapping, and keeps the int/FP vectors
// of currently mapped physical registers used for recovery.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Retire_Valid_bus         per-slot retire valid (slot 0 oldest)
//   Retire_WE_bus            per-slot writes rd
//   Retire_rdType_bus        per-slot register type (REG_TYPE_FP = FP)
//   Retire_rd_bus            per-slot architectural rd, 5 bits each
//   Retire_prd_bus           per-slot new physical rd, PRF_MAX_LEN bits each
//   WriteFree_WE_bus         registered per-slot free request
//   WriteFree_rdType_bus     registered per-slot type of freed register
//   WriteFree_prd_bus        registered per-slot freed physical register
//   Int_RetirePhyMapBits     int physical registers mapped by this table
//   Fp_RetirePhyMapBits      FP physical registers mapped by this table
module retire_rat
  import retire_rat_pkg::*;
#(
  parameter int RETIRE_RATE   = DEF_RETIRE_RATE,
  parameter int INT_PRF_DEPTH = DEF_INT_PRF_DEPTH,
  parameter int INT_PRF_LEN   = DEF_INT_PRF_LEN,
  parameter int FP_PRF_DEPTH  = DEF_FP_PRF_DEPTH,
  parameter int FP_PRF_LEN    = DEF_FP_PRF_LEN,
  parameter int PRF_MAX_LEN   = DEF_PRF_MAX_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RETIRE_RATE-1:0]          Retire_Valid_bus,
  input  logic [RETIRE_RATE-1:0]          Retire_WE_bus,
  input  logic [RETIRE_RATE-1:0]          Retire_rdType_bus,
  input  logic [RETIRE_RATE*5-1:0]        Retire_rd_bus,
  input  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] Retire_prd_bus,
  output logic [RETIRE_RATE-1:0]          WriteFree_WE_bus,
  output logic [RETIRE_RATE-1:0]          WriteFree_rdType_bus,
  output logic [RETIRE_RATE*PRF_MAX_LEN-1:0] WriteFree_prd_bus,
  output logic [INT_PRF_DEPTH-1:0]        Int_RetirePhyMapBits,
  output logic [FP_PRF_DEPTH-1:0]         Fp_RetirePhyMapBits
);

  logic [RETIRE_RATE-1:0]             int_act_s;
  logic [RETIRE_RATE-1:0]             fp_act_s;
  logic [RETIRE_RATE-1:0]             int_free_s;
  logic [RETIRE_RATE-1:0]             fp_free_s;
  logic [RETIRE_RATE*INT_PRF_LEN-1:0] int_prd_s;
  logic [RETIRE_RATE*INT_PRF_LEN-1:0] int_old_s;
  logic [RETIRE_RATE*FP_PRF_LEN-1:0]  fp_prd_s;
  logic [RETIRE_RATE*FP_PRF_LEN-1:0]  fp_old_s;

  logic [RETIRE_RATE-1:0]             fr_we_s;
  logic [RETIRE_RATE-1:0]             fr_ty_s;
  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] fr_prd_s;

  logic [RETIRE_RATE-1:0]             fr_we_r;
  logic [RETIRE_RATE-1:0]             fr_ty_r;
  logic [RETIRE_RATE*PRF_MAX_LEN-1:0] fr_prd_r;

  // Slot decode and type demux; each table only sees its own type's writes.
  always_comb begin
    int_act_s = '0;
    fp_act_s  = '0;
    int_prd_s = '0;
    fp_prd_s  = '0;
    for (int k = 0; k < RETIRE_RATE; k++) begin
      if (Retire_Valid_bus[k] && Retire_WE_bus[k]) begin
        if (Retire_rdType_bus[k] == REG_TYPE_FP) begin
          fp_act_s[k] = 1'b1;
        end else begin
          int_act_s[k] = 1'b1;
        end
      end else begin
        int_act_s[k] = 1'b0;
      end
      int_prd_s[k*INT_PRF_LEN +: INT_PRF_LEN] = Retire_prd_bus[k*PRF_MAX_LEN +: INT_PRF_LEN];
      fp_prd_s[k*FP_PRF_LEN +: FP_PRF_LEN]    = Retire_prd_bus[k*PRF_MAX_LEN +: FP_PRF_LEN];
    end
  end

  retire_rat_table #(
    .DEPTH       (INT_PRF_DEPTH),
    .LEN         (INT_PRF_LEN),
    .SUPPRESS_R0 (1'b1),
    .RATE        (RETIRE_RATE)
  ) u_int_table (
    .clk      (clk),
    .rst      (rst),
    .act      (int_act_s),
    .rd       (Retire_rd_bus),
    .prd      (int_prd_s),
    .free_en  (int_free_s),
    .old_prd  (int_old_s),
    .map_bits (Int_RetirePhyMapBits)
  );

  retire_rat_table #(
    .DEPTH       (FP_PRF_DEPTH),
    .LEN         (FP_PRF_LEN),
    .SUPPRESS_R0 (1'b0),
    .RATE        (RETIRE_RATE)
  ) u_fp_table (
    .clk      (clk),
    .rst      (rst),
    .act      (fp_act_s),
    .rd       (Retire_rd_bus),
    .prd      (fp_prd_s),
    .free_en  (fp_free_s),
    .old_prd  (fp_old_s),
    .map_bits (Fp_RetirePhyMapBits)
  );

  // Free request for the next cycle; inactive slots present all-zero fields.
  always_comb begin
    fr_we_s  = '0;
    fr_ty_s  = '0;
    fr_prd_s = '0;
    for (int k = 0; k < RETIRE_RATE; k++) begin
      if (int_free_s[k]) begin
        fr_we_s[k] = 1'b1;
        fr_ty_s[k] = REG_TYPE_INT;
        fr_prd_s[k*PRF_MAX_LEN +: INT_PRF_LEN] = int_old_s[k*INT_PRF_LEN +: INT_PRF_LEN];
      end else if (fp_free_s[k]) begin
        fr_we_s[k] = 1'b1;
        fr_ty_s[k] = REG_TYPE_FP;
        fr_prd_s[k*PRF_MAX_LEN +: FP_PRF_LEN] = fp_old_s[k*FP_PRF_LEN +: FP_PRF_LEN];
      end else begin
        fr_we_s[k] = 1'b0;
      end
    end
  end

  // Free output registers: valid for exactly one cycle after retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_we_r  <= '0;
      fr_ty_r  <= '0;
      fr_prd_r <= '0;
    end else begin
      fr_we_r  <= fr_we_s;
      fr_ty_r  <= fr_ty_s;
      fr_prd_r <= fr_prd_s;
    end
  end

  assign WriteFree_WE_bus     = fr_we_r;
  assign WriteFree_rdType_bus = fr_ty_r;
  assign WriteFree_prd_bus    = fr_prd_r;

endmodule
